// File: rtl/ac_zone_controller.sv
// Multi-zone heat/cool controller: per-zone hysteresis FSM with minimum-run and
// minimum-off compressor protection and an energy-save override.
module ac_zone_controller #(
  parameter int ZONES       = 4,
  parameter int TEMP_W      = 8,
  parameter int HYST        = 2,
  parameter int MIN_RUN_CYC = 16,
  parameter int MIN_OFF_CYC = 16
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  logic                      sample_i,
  input  logic [ZONES*TEMP_W-1:0]   temp_i,
  input  logic [TEMP_W-1:0]         setpoint_i,
  input  logic [ZONES-1:0]          energy_save_i,
  output logic [ZONES-1:0]          AC_heat_o,
  output logic [ZONES-1:0]          AC_cool_o,
  output logic [2*ZONES-1:0]        state_o
);

  localparam int CNT_MAX = (MIN_RUN_CYC > MIN_OFF_CYC) ? MIN_RUN_CYC : MIN_OFF_CYC;
  localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

  localparam logic [CNT_W-1:0]  RUN_MAX  = CNT_W'(MIN_RUN_CYC - 1);
  localparam logic [CNT_W-1:0]  OFF_LOAD = CNT_W'(MIN_OFF_CYC - 1);
  localparam logic [TEMP_W:0]   HYST_E   = (TEMP_W+1)'(HYST);
  localparam logic [TEMP_W:0]   T_MAX    = {1'b0, {TEMP_W{1'b1}}};

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_HEAT = 2'b01,
    ST_COOL = 2'b10,
    ST_REST = 2'b11
  } zone_state_e;

  // Thresholds carry one extra bit so the setpoint +/- band saturates cleanly.
  logic [TEMP_W:0] sp_ext, lo, hi, hi_sum;

  assign sp_ext = {1'b0, setpoint_i};
  assign lo     = (sp_ext >= HYST_E) ? (sp_ext - HYST_E) : '0;
  assign hi_sum = sp_ext + HYST_E;
  assign hi     = (hi_sum > T_MAX) ? T_MAX : hi_sum;

  for (genvar z = 0; z < ZONES; z++) begin : g_zone
    zone_state_e      state_q, state_d;
    logic [CNT_W-1:0] run_q, run_d;
    logic [CNT_W-1:0] off_q, off_d;
    logic             heat_q, cool_q;
    logic [TEMP_W:0]  temp_z;

    assign temp_z = {1'b0, temp_i[z*TEMP_W +: TEMP_W]};

    always_comb begin
      // NOTE: every combinational output gets a default first, so no path can infer a latch.
      state_d = state_q;
      run_d   = run_q;
      off_d   = off_q;
      case (state_q)
        ST_IDLE: begin
          if (sample_i && !energy_save_i[z]) begin
            if (temp_z < lo) begin
              state_d = ST_HEAT;
              run_d   = '0;
            end else if (temp_z > hi) begin
              state_d = ST_COOL;
              run_d   = '0;
            end
          end
        end
        ST_HEAT: begin
          if (energy_save_i[z]) begin
            state_d = ST_REST;
            off_d   = OFF_LOAD;
          end else if (sample_i && (temp_z >= sp_ext) && (run_q == RUN_MAX)) begin
            state_d = ST_REST;
            off_d   = OFF_LOAD;
          end else if (run_q != RUN_MAX) begin
            run_d = run_q + CNT_W'(1);
          end
        end
        ST_COOL: begin
          if (energy_save_i[z]) begin
            state_d = ST_REST;
            off_d   = OFF_LOAD;
          end else if (sample_i && (temp_z <= sp_ext) && (run_q == RUN_MAX)) begin
            state_d = ST_REST;
            off_d   = OFF_LOAD;
          end else if (run_q != RUN_MAX) begin
            run_d = run_q + CNT_W'(1);
          end
        end
        default: begin
          if (off_q == '0) begin
            state_d = ST_IDLE;
          end else begin
            off_d = off_q - CNT_W'(1);
          end
        end
      endcase
    end

    // NOTE: sequential state uses non-blocking assignments only; all flops here are
    // plain registers (no memories), so each one is reset to a defined lockout value.
    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        state_q <= ST_REST;
        run_q   <= '0;
        off_q   <= OFF_LOAD;
        heat_q  <= 1'b0;
        cool_q  <= 1'b0;
      end else begin
        state_q <= state_d;
        run_q   <= run_d;
        off_q   <= off_d;
        heat_q  <= (state_d == ST_HEAT);
        cool_q  <= (state_d == ST_COOL);
      end
    end

    assign AC_heat_o[z]        = heat_q;
    assign AC_cool_o[z]        = cool_q;
    assign state_o[2*z +: 2]   = state_q;
  end

endmodule
